// File: rtl/bit_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bit_stream_decoder
// Brief    : NRZI line decoder with bit unstuffing, PID/CRC5/CRC16/length
//            checking and one-cycle packet result pulses at end-of-packet.
// Revision : 1.0 - initial release
// ============================================================================
module bit_stream_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        in_valid,
    input  logic        eop,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic [7:0]  pid_out,
    output logic [6:0]  addr_out,
    output logic [3:0]  endp_out,
    output logic [63:0] data_out
);
    localparam logic [2:0]  c_ST_IDLE      = 3'd0;
    localparam logic [2:0]  c_ST_PID       = 3'd1;
    localparam logic [2:0]  c_ST_BODY      = 3'd2;
    localparam logic [2:0]  c_ST_WAIT_EOP  = 3'd3;
    localparam logic [2:0]  c_ST_DISCARD   = 3'd4;

    localparam logic [1:0]  c_ERR_PID      = 2'd0;
    localparam logic [1:0]  c_ERR_CRC      = 2'd1;
    localparam logic [1:0]  c_ERR_STUFF    = 2'd2;
    localparam logic [1:0]  c_ERR_LENGTH   = 2'd3;

    localparam logic [1:0]  c_KIND_TOKEN   = 2'd0;
    localparam logic [1:0]  c_KIND_DATA    = 2'd1;
    localparam logic [1:0]  c_KIND_HAND    = 2'd2;

    localparam logic [7:0]  c_SYNC         = 8'b0000_0001;
    localparam logic [6:0]  c_PID_LAST     = 7'd7;
    localparam logic [6:0]  c_TOKEN_LAST   = 7'd15;
    localparam logic [6:0]  c_DATA_LAST    = 7'd79;
    localparam logic [4:0]  c_CRC5_POLY    = 5'b00101;
    localparam logic [15:0] c_CRC16_POLY   = 16'h8005;
    localparam logic [4:0]  c_CRC5_RES     = 5'b01100;
    localparam logic [15:0] c_CRC16_RES    = 16'h800D;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_prev_line;
    logic [7:0]  r_sync_sr;
    logic [2:0]  r_ones;
    logic [6:0]  r_cnt;
    logic [7:0]  r_pid;
    logic [1:0]  r_kind;
    logic [79:0] r_body;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic [1:0]  r_err_latched;

    logic        w_bit_en;
    logic        w_dec;
    logic        w_active;
    logic        w_stuff_slot;
    logic        w_stuff_drop;
    logic        w_stuff_err;
    logic        w_data_bit;
    logic        w_sync_hit;
    logic [7:0]  w_pid_byte;
    logic        w_pid_ok;
    logic [1:0]  w_pid_kind;
    logic        w_pid_last;
    logic        w_body_last;
    logic [4:0]  w_crc5_next;
    logic [15:0] w_crc16_next;
    logic        w_crc_ok;
    logic        w_emit_valid;
    logic        w_emit_err;
    logic [1:0]  w_emit_code;
    logic        w_err_set;
    logic [1:0]  w_err_new;
    logic [63:0] w_data_bytes;

    assign w_bit_en     = in_valid & ~eop;
    assign w_dec        = (bit_in == r_prev_line);
    assign w_active     = (r_state == c_ST_PID) | (r_state == c_ST_BODY) | (r_state == c_ST_WAIT_EOP);
    // A decoded bit following six consecutive ones is a stuff slot, never data.
    assign w_stuff_slot = (r_ones == 3'd6);
    assign w_stuff_drop = w_bit_en & w_active & w_stuff_slot & ~w_dec;
    assign w_stuff_err  = w_bit_en & w_active & w_stuff_slot & w_dec;
    assign w_data_bit   = w_bit_en & w_active & ~w_stuff_slot;
    assign w_sync_hit   = w_bit_en & (r_state == c_ST_IDLE) & ({r_sync_sr[6:0], w_dec} == c_SYNC);

    assign w_pid_byte   = {w_dec, r_pid[7:1]};
    assign w_pid_last   = (r_state == c_ST_PID) & w_data_bit & (r_cnt == c_PID_LAST);
    assign w_body_last  = (r_state == c_ST_BODY) & w_data_bit &
                          (r_cnt == ((r_kind == c_KIND_DATA) ? c_DATA_LAST : c_TOKEN_LAST));

    assign w_crc5_next  = {r_crc5[3:0], 1'b0} ^ ((w_dec ^ r_crc5[4]) ? c_CRC5_POLY : 5'd0);
    assign w_crc16_next = {r_crc16[14:0], 1'b0} ^ ((w_dec ^ r_crc16[15]) ? c_CRC16_POLY : 16'd0);
    assign w_crc_ok     = (r_kind == c_KIND_DATA) ? (w_crc16_next == c_CRC16_RES)
                                                  : (w_crc5_next == c_CRC5_RES);

    always_comb begin
        w_pid_ok   = 1'b0;
        w_pid_kind = c_KIND_TOKEN;
        if (w_pid_byte[7:4] == ~w_pid_byte[3:0]) begin
            case (w_pid_byte[3:0])
                4'h1, 4'h9, 4'hD: begin w_pid_ok = 1'b1; w_pid_kind = c_KIND_TOKEN; end
                4'h3, 4'hB:       begin w_pid_ok = 1'b1; w_pid_kind = c_KIND_DATA;  end
                4'h2, 4'hA, 4'hE: begin w_pid_ok = 1'b1; w_pid_kind = c_KIND_HAND;  end
                default:          begin w_pid_ok = 1'b0; w_pid_kind = c_KIND_TOKEN; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (eop) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sync_hit) w_next_state = c_ST_PID;
                end
                c_ST_PID: begin
                    if (w_stuff_err)                 w_next_state = c_ST_DISCARD;
                    else if (w_pid_last && !w_pid_ok) w_next_state = c_ST_DISCARD;
                    else if (w_pid_last)             w_next_state = (w_pid_kind == c_KIND_HAND) ? c_ST_WAIT_EOP : c_ST_BODY;
                end
                c_ST_BODY: begin
                    if (w_stuff_err)      w_next_state = c_ST_DISCARD;
                    else if (w_body_last) w_next_state = w_crc_ok ? c_ST_WAIT_EOP : c_ST_DISCARD;
                end
                c_ST_WAIT_EOP: begin
                    if (w_stuff_err || w_data_bit) w_next_state = c_ST_DISCARD;
                end
                c_ST_DISCARD: begin
                    w_next_state = c_ST_DISCARD;
                end
                default: begin
                    w_next_state = c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_emit_valid = eop & (r_state == c_ST_WAIT_EOP);
        w_emit_err   = eop & ((r_state == c_ST_PID) | (r_state == c_ST_BODY) | (r_state == c_ST_DISCARD));
        w_emit_code  = (r_state == c_ST_DISCARD) ? r_err_latched : c_ERR_LENGTH;
        w_err_set    = 1'b0;
        w_err_new    = c_ERR_PID;
        if (!eop) begin
            if (w_stuff_err) begin
                w_err_set = 1'b1;
                w_err_new = c_ERR_STUFF;
            end else if (w_pid_last && !w_pid_ok) begin
                w_err_set = 1'b1;
                w_err_new = c_ERR_PID;
            end else if (w_body_last && !w_crc_ok) begin
                w_err_set = 1'b1;
                w_err_new = c_ERR_CRC;
            end else if ((r_state == c_ST_WAIT_EOP) && w_data_bit) begin
                w_err_set = 1'b1;
                w_err_new = c_ERR_LENGTH;
            end
        end
    end

    // Body bits are shifted in LSB first, so body bit i ends up in r_body[i].
    always_comb begin
        w_data_bytes = 64'd0;
        for (int k = 0; k < 8; k++) begin
            w_data_bytes[63 - 8*k -: 8] = r_body[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_line   <= 1'b1;
            r_sync_sr     <= 8'hFF;
            r_ones        <= 3'd0;
            r_cnt         <= 7'd0;
            r_pid         <= 8'd0;
            r_kind        <= c_KIND_TOKEN;
            r_body        <= 80'd0;
            r_crc5        <= 5'h1F;
            r_crc16       <= 16'hFFFF;
            r_err_latched <= c_ERR_PID;
            pkt_valid     <= 1'b0;
            pkt_err       <= 1'b0;
            err_code      <= 2'd0;
            pid_out       <= 8'd0;
            addr_out      <= 7'd0;
            endp_out      <= 4'd0;
            data_out      <= 64'd0;
        end else begin
            if (eop)           r_prev_line <= 1'b1;
            else if (in_valid) r_prev_line <= bit_in;

            // An idle line decodes as ones, so 0xFF can never complete a false SYNC.
            if (eop || r_state != c_ST_IDLE) r_sync_sr <= 8'hFF;
            else if (w_bit_en)               r_sync_sr <= {r_sync_sr[6:0], w_dec};

            if (eop)               r_ones <= 3'd0;
            else if (w_sync_hit)   r_ones <= 3'd1;
            else if (w_stuff_drop) r_ones <= 3'd0;
            else if (w_data_bit)   r_ones <= w_dec ? r_ones + 3'd1 : 3'd0;

            if (w_sync_hit || w_pid_last) r_cnt <= 7'd0;
            else if (w_data_bit)          r_cnt <= r_cnt + 7'd1;

            if (w_sync_hit)                               r_err_latched <= c_ERR_PID;
            else if (w_err_set)                           r_err_latched <= w_err_new;

            if ((r_state == c_ST_PID) && w_data_bit) r_pid <= w_pid_byte;
            if (w_pid_last) begin
                r_kind  <= w_pid_kind;
                r_crc5  <= 5'h1F;
                r_crc16 <= 16'hFFFF;
            end
            if ((r_state == c_ST_BODY) && w_data_bit) begin
                r_body  <= {w_dec, r_body[79:1]};
                r_crc5  <= w_crc5_next;
                r_crc16 <= w_crc16_next;
            end

            pkt_valid <= w_emit_valid;
            pkt_err   <= w_emit_err;
            if (w_emit_err) err_code <= w_emit_code;
            if (w_emit_valid) begin
                pid_out  <= r_pid;
                addr_out <= (r_kind == c_KIND_TOKEN) ? r_body[70:64] : 7'd0;
                endp_out <= (r_kind == c_KIND_TOKEN) ? r_body[74:71] : 4'd0;
                data_out <= (r_kind == c_KIND_DATA)  ? w_data_bytes  : 64'd0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bit_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_stream_decoder
// Brief    : Directed and randomized packet bench for bit_stream_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_stream_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        in_valid;
    logic        eop;
    logic        pkt_valid;
    logic        pkt_err;
    logic [1:0]  err_code;
    logic [7:0]  pid_out;
    logic [6:0]  addr_out;
    logic [3:0]  endp_out;
    logic [63:0] data_out;

    bit_stream_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .in_valid (in_valid),
        .eop      (eop),
        .pkt_valid(pkt_valid),
        .pkt_err  (pkt_err),
        .err_code (err_code),
        .pid_out  (pid_out),
        .addr_out (addr_out),
        .endp_out (endp_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int pulses = 0;
    int both   = 0;
    int p_start;
    logic line;

    bit pl[$];
    bit ln[$];

    logic [7:0]  h_pid;
    logic [6:0]  h_addr;
    logic [3:0]  h_endp;
    logic [63:0] h_data;

    always @(negedge clk) begin
        if (pkt_valid || pkt_err) pulses++;
        if (pkt_valid && pkt_err) both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic v, input logic e);
        bit_in   = b;
        in_valid = v;
        eop      = e;
        @(posedge clk);
        #1;
    endtask

    function automatic void push_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) pl.push_back(v[i]);
    endfunction

    // Polynomial division remainder of a bit slice of pl, register preset to all ones.
    function automatic int unsigned crc_rem(input int start, input int n, input int width, input int unsigned poly);
        int unsigned mask = (32'd1 << width) - 32'd1;
        int unsigned r    = mask;
        for (int i = 0; i < n; i++) begin
            bit fb = r[width-1] ^ pl[start+i];
            r = (r << 1) & mask;
            if (fb) r = r ^ poly;
        end
        return r;
    endfunction

    function automatic void push_crc(input int start, input int n, input int width, input int unsigned poly);
        int unsigned mask = (32'd1 << width) - 32'd1;
        int unsigned fld  = ~crc_rem(start, n, width, poly) & mask;
        for (int j = width - 1; j >= 0; j--) pl.push_back(fld[j]);
    endfunction

    function automatic void make_token(input logic [7:0] p, input logic [6:0] a, input logic [3:0] e);
        pl.delete();
        push_bits(64'(p), 8);
        push_bits(64'(a), 7);
        push_bits(64'(e), 4);
        push_crc(8, 11, 5, 32'h05);
    endfunction

    function automatic void make_data(input logic [7:0] p, input logic [63:0] d);
        pl.delete();
        push_bits(64'(p), 8);
        for (int k = 0; k < 8; k++) push_bits(64'(d[63 - 8*k -: 8]), 8);
        push_crc(8, 64, 16, 32'h8005);
    endfunction

    function automatic void make_hs(input logic [7:0] p);
        pl.delete();
        push_bits(64'(p), 8);
    endfunction

    // Outcome of the logical (unstuffed) bits following SYNC, terminated by eop.
    task automatic model(output bit ok, output logic [1:0] code, output logic [7:0] p,
                         output logic [6:0] a, output logic [3:0] e, output logic [63:0] d);
        int n = pl.size();
        int body;
        int cw;
        int unsigned poly;
        int unsigned fld;
        int unsigned mask;
        ok = 0; code = 2'd3; p = '0; a = '0; e = '0; d = '0;
        if (n < 8) return;
        for (int i = 0; i < 8; i++) p[i] = pl[i];
        if (!((p[7:4] == ~p[3:0]) && (p inside {8'hE1, 8'h69, 8'h2D, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E}))) begin
            code = 2'd0;
            return;
        end
        if (p inside {8'hE1, 8'h69, 8'h2D})  begin body = 16; cw = 5;  poly = 32'h05;   end
        else if (p inside {8'hC3, 8'h4B})    begin body = 80; cw = 16; poly = 32'h8005; end
        else                                 begin body = 0;  cw = 0;  poly = 0;        end
        if (n < 8 + body) begin code = 2'd3; return; end
        if (body > 0) begin
            mask = (32'd1 << cw) - 32'd1;
            fld  = 0;
            for (int j = 0; j < cw; j++) fld = (fld << 1) | 32'(pl[8 + body - cw + j]);
            if (fld != (~crc_rem(8, body - cw, cw, poly) & mask)) begin code = 2'd1; return; end
        end
        if (n > 8 + body) begin code = 2'd3; return; end
        ok = 1;
        if (body == 16) begin
            for (int i = 0; i < 7; i++) a[i] = pl[8 + i];
            for (int i = 0; i < 4; i++) e[i] = pl[15 + i];
        end else if (body == 80) begin
            for (int i = 0; i < 64; i++) d[56 - 8*(i/8) + (i%8)] = pl[8 + i];
        end
    endtask

    // SYNC + pl, optionally bit-stuffed, NRZI encoded and driven with optional stalls.
    task automatic send_frame(input bit do_stuff, input int stall_at, input int stall_len,
                              input bit rnd_stall, input int max_bits);
        bit fr[$];
        int ones = 0;
        p_start = pulses;
        for (int i = 0; i < 7; i++) fr.push_back(1'b0);
        fr.push_back(1'b1);
        foreach (pl[i]) fr.push_back(pl[i]);
        ln.delete();
        foreach (fr[i]) begin
            ln.push_back(fr[i]);
            if (do_stuff) begin
                ones = fr[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    ln.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        repeat (3) cyc(line, 1'b1, 1'b0);
        foreach (ln[i]) begin
            if (max_bits >= 0 && i >= max_bits) break;
            if (i == stall_at) repeat (stall_len) cyc(1'($urandom), 1'b0, 1'b0);
            if (rnd_stall && $urandom_range(0, 9) == 0)
                repeat ($urandom_range(1, 3)) cyc(1'($urandom), 1'b0, 1'b0);
            if (!ln[i]) line = ~line;
            cyc(line, 1'b1, 1'b0);
        end
    endtask

    task automatic end_check(input string tag, input bit pulse, input bit ok, input logic [1:0] code,
                             input logic [7:0] p, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
        cyc(1'($urandom), 1'($urandom), 1'b1);
        line = 1'b1;
        if (pulse && ok) begin
            h_pid = p; h_addr = a; h_endp = e; h_data = d;
        end
        chk({tag, "/pkt_valid"}, 64'(pkt_valid), 64'(pulse && ok));
        chk({tag, "/pkt_err"},   64'(pkt_err),   64'(pulse && !ok));
        if (pulse && !ok) chk({tag, "/err_code"}, 64'(err_code), 64'(code));
        chk({tag, "/pid_out"},  64'(pid_out),  64'(h_pid));
        chk({tag, "/addr_out"}, 64'(addr_out), 64'(h_addr));
        chk({tag, "/endp_out"}, 64'(endp_out), 64'(h_endp));
        chk({tag, "/data_out"}, data_out, h_data);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk({tag, "/pulse_count"}, 64'(pulses - p_start), 64'(pulse));
    endtask

    initial begin
        bit          ok;
        logic [1:0]  code;
        logic [7:0]  p;
        logic [6:0]  a;
        logic [3:0]  e;
        logic [63:0] d;
        int          kind;
        int          corr;
        logic [7:0]  tokp [3] = '{8'hE1, 8'h69, 8'h2D};
        logic [7:0]  datp [2] = '{8'hC3, 8'h4B};
        logic [7:0]  hsp  [3] = '{8'hD2, 8'h5A, 8'h1E};

        h_pid = '0; h_addr = '0; h_endp = '0; h_data = '0;
        line = 1'b1;
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        chk("reset/pkt_valid", 64'(pkt_valid), 64'd0);
        chk("reset/pkt_err",   64'(pkt_err),   64'd0);
        chk("reset/err_code",  64'(err_code),  64'd0);
        chk("reset/pid_out",   64'(pid_out),   64'd0);
        chk("reset/addr_out",  64'(addr_out),  64'd0);
        chk("reset/data_out",  data_out,       64'd0);
        rst = 1'b0;
        repeat (2) cyc(1'b1, 1'b1, 1'b0);

        p_start = pulses;
        end_check("idle_eop", 1'b0, 1'b0, 2'd0, '0, '0, '0, '0);

        make_token(8'hE1, 7'd5, 4'd4);
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b0, -1);
        end_check("out_token", 1'b1, ok, code, p, a, e, d);
        chk("out_token/pid_const",  64'(pid_out),  64'hE1);
        chk("out_token/addr_const", 64'(addr_out), 64'h05);
        chk("out_token/endp_const", 64'(endp_out), 64'h4);

        make_data(8'hC3, 64'hCAFEBABEDEADBEEF);
        model(ok, code, p, a, e, d);
        send_frame(1'b1, 40, 5, 1'b0, -1);
        end_check("data0", 1'b1, ok, code, p, a, e, d);
        chk("data0/data_const", data_out, 64'hCAFEBABEDEADBEEF);

        make_hs(8'hD2);
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b0, -1);
        end_check("ack", 1'b1, ok, code, p, a, e, d);
        make_hs(8'hE0);
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b0, -1);
        end_check("bad_pid", 1'b1, ok, code, p, a, e, d);
        chk("bad_pid/pid_hold", 64'(pid_out), 64'hD2);

        make_data(8'h4B, {$urandom, $urandom});
        pl[8 + $urandom_range(0, 63)] ^= 1'b1;
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b1, -1);
        end_check("data1_crc", 1'b1, ok, code, p, a, e, d);
        chk("data1_crc/code_const", 64'(err_code), 64'd1);

        make_token(8'hE1, 7'h7F, 4'hF);
        send_frame(1'b0, -1, 0, 1'b0, -1);
        end_check("stuff", 1'b1, 1'b0, 2'd2, '0, '0, '0, '0);

        make_token(8'h69, 7'd9, 4'd1);
        while (pl.size() > 3) void'(pl.pop_back());
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b0, -1);
        end_check("short_pid", 1'b1, ok, code, p, a, e, d);
        chk("short_pid/code_const", 64'(err_code), 64'd3);

        make_data(8'hC3, {$urandom, $urandom});
        send_frame(1'b1, -1, 0, 1'b0, 50);
        rst = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        line = 1'b1;
        h_pid = '0; h_addr = '0; h_endp = '0; h_data = '0;
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        chk("rst_abort/pulse_count", 64'(pulses - p_start), 64'd0);
        chk("rst_abort/pid_out", 64'(pid_out), 64'd0);
        make_hs(8'hD2);
        model(ok, code, p, a, e, d);
        send_frame(1'b1, -1, 0, 1'b0, -1);
        end_check("rst_ack", 1'b1, ok, code, p, a, e, d);
        chk("rst_ack/pid_const", 64'(pid_out), 64'hD2);

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       make_token(tokp[$urandom_range(0, 2)], 7'($urandom), 4'($urandom));
                1:       make_data(datp[$urandom_range(0, 1)], {$urandom, $urandom});
                2:       make_hs(hsp[$urandom_range(0, 2)]);
                default: begin
                    make_token(8'($urandom), 7'($urandom), 4'($urandom));
                end
            endcase
            corr = $urandom_range(0, 5);
            if (corr == 3 && pl.size() > 8) pl[$urandom_range(8, pl.size() - 1)] ^= 1'b1;
            if (corr == 4) begin
                int keep = $urandom_range(0, pl.size() - 1);
                while (pl.size() > keep) void'(pl.pop_back());
            end
            if (corr == 5) repeat ($urandom_range(1, 4)) pl.push_back(1'($urandom));
            model(ok, code, p, a, e, d);
            send_frame(1'b1, -1, 0, 1'b1, -1);
            end_check($sformatf("rand%0d_k%0d_c%0d", t, kind, corr), 1'b1, ok, code, p, a, e, d);
        end

        chk("never_both", 64'(both), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
`default_nettype wire
